// File: rtl/zs_packer.sv
// Bit-serial to zero-skip packer: rebuilds LSB-first 8-bit pixels and writes 9-bit {skip, pixel}
// words to the feature SRAM; word[8]=1 marks that the following pixel was zero and not stored.
module zs_packer #(
   parameter int SRAM_DEPTH = 1024,
   parameter bit ZS_ENABLE  = 1'b1,
   localparam int AW        = $clog2(SRAM_DEPTH)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          pack_start,
   input  logic [AW-1:0] start_addr,
   input  logic [AW-1:0] img_width_size,
   input  logic [AW-1:0] img_height_size,
   input  logic          serial_input,
   input  logic          serial_en,
   output logic          pack_idle,
   output logic          sram_en,
   output logic          sram_we,
   output logic [AW-1:0] sram_addr,
   output logic [8:0]    sram_data,
   output logic          frame_done,
   output logic [AW:0]   word_count
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]    state;
   logic [2:0]    bit_cnt;
   logic [6:0]    shreg;
   logic [AW:0]   pix_left;
   logic [AW-1:0] wr_addr;
   logic          pend_valid;
   logic          pend_flag;
   logic [7:0]    pend_data;

   logic [AW:0]   frame_w;
   logic [AW:0]   frame_h;
   logic [AW:0]   frame_pixels;
   logic [7:0]    byte_val;
   logic          byte_done;

   // Sizes are encoded as dimension-1; the caller keeps the product within SRAM_DEPTH.
   assign frame_w      = {1'b0, img_width_size} + 1'b1;
   assign frame_h      = {1'b0, img_height_size} + 1'b1;
   assign frame_pixels = frame_w * frame_h;

   assign byte_val  = {serial_input, shreg};
   assign byte_done = (state == ST_RUN) && serial_en && (bit_cnt == 3'd7);

   assign pack_idle = (state == ST_IDLE);
   assign sram_en   = sram_we;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         pix_left   <= '0;
         wr_addr    <= '0;
         pend_valid <= 1'b0;
         pend_flag  <= 1'b0;
         pend_data  <= '0;
         sram_we    <= 1'b0;
         sram_addr  <= '0;
         sram_data  <= '0;
         frame_done <= 1'b0;
         word_count <= '0;
      end else begin
         // NOTE: strobes default low each cycle; the branches below raise them for exactly one cycle.
         sram_we    <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pack_start) begin
                  state      <= ST_RUN;
                  wr_addr    <= start_addr;
                  pix_left   <= frame_pixels;
                  word_count <= '0;
                  bit_cnt    <= '0;
                  pend_valid <= 1'b0;
                  pend_flag  <= 1'b0;
               end
            end
            ST_RUN: begin
               if (serial_en) begin
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt != 3'd7) shreg[bit_cnt] <= serial_input;
               end
               if (byte_done) begin
                  pix_left <= pix_left - 1'b1;
                  if (pix_left == (AW+1)'(1)) state <= ST_FLUSH;
                  if (!pend_valid) begin
                     pend_valid <= 1'b1;
                     pend_flag  <= 1'b0;
                     pend_data  <= byte_val;
                  end else if (ZS_ENABLE && !pend_flag && (byte_val == 8'h00)) begin
                     // A zero following an unflagged word is absorbed; a flagged word never absorbs again.
                     pend_flag <= 1'b1;
                  end else begin
                     sram_we    <= 1'b1;
                     sram_addr  <= wr_addr;
                     sram_data  <= {pend_flag, pend_data};
                     wr_addr    <= wr_addr + 1'b1;
                     word_count <= word_count + 1'b1;
                     pend_flag  <= 1'b0;
                     pend_data  <= byte_val;
                  end
               end
            end
            ST_FLUSH: begin
               sram_we    <= 1'b1;
               sram_addr  <= wr_addr;
               sram_data  <= {pend_flag, pend_data};
               wr_addr    <= wr_addr + 1'b1;
               word_count <= word_count + 1'b1;
               pend_valid <= 1'b0;
               frame_done <= 1'b1;
               state      <= ST_DONE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_zs_packer.sv
// Self-checking bench for zs_packer: random pixel frames are serialised LSB-first into a ZS_ENABLE=1
// and a ZS_ENABLE=0 instance; captured SRAM writes are compared with a pixel-level zero-skip model.
module tb_zs_packer;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          pack_start = 1'b0;
   logic [AW-1:0] start_addr = '0;
   logic [AW-1:0] img_width_size = '0;
   logic [AW-1:0] img_height_size = '0;
   logic          serial_input = 1'b0;
   logic          serial_en = 1'b0;

   logic          idle1, en1, we1, fd1;
   logic [AW-1:0] addr1;
   logic [8:0]    data1;
   logic [AW:0]   wc1;
   logic          idle0, en0, we0, fd0;
   logic [AW-1:0] addr0;
   logic [8:0]    data0;
   logic [AW:0]   wc0;

   always #5 clk = ~clk;

   zs_packer #(.SRAM_DEPTH(1024), .ZS_ENABLE(1'b1)) dut (
      .clk(clk), .reset_n(reset_n), .pack_start(pack_start), .start_addr(start_addr),
      .img_width_size(img_width_size), .img_height_size(img_height_size),
      .serial_input(serial_input), .serial_en(serial_en), .pack_idle(idle1), .sram_en(en1),
      .sram_we(we1), .sram_addr(addr1), .sram_data(data1), .frame_done(fd1), .word_count(wc1)
   );

   zs_packer #(.SRAM_DEPTH(1024), .ZS_ENABLE(1'b0)) dut_nz (
      .clk(clk), .reset_n(reset_n), .pack_start(pack_start), .start_addr(start_addr),
      .img_width_size(img_width_size), .img_height_size(img_height_size),
      .serial_input(serial_input), .serial_en(serial_en), .pack_idle(idle0), .sram_en(en0),
      .sram_we(we0), .sram_addr(addr0), .sram_data(data0), .frame_done(fd0), .word_count(wc0)
   );

   int checks = 0;
   int failures = 0;

   // Captured writes as {addr, word}; counters are only read as deltas by the tests.
   logic [AW+8:0] wq1[$];
   logic [AW+8:0] wq0[$];
   int            fdc1 = 0;
   int            fdc0 = 0;
   int            en_bad = 0;
   logic          idle_at_done = 1'b1;

   always @(negedge clk) begin
      if (we1) wq1.push_back({addr1, data1});
      if (we0) wq0.push_back({addr0, data0});
      if (fd1) begin
         fdc1 <= fdc1 + 1;
         idle_at_done <= idle1;
      end
      if (fd0) fdc0 <= fdc0 + 1;
      if ((en1 !== we1) || (en0 !== we0)) en_bad <= en_bad + 1;
   end

   logic [7:0] pix_q[$];
   logic [8:0] exp1_q[$];
   logic [8:0] exp0_q[$];

   // Each stored pixel is followed by its successor unless that successor is zero and
   // compression is on, in which case the stored word is flagged and the zero disappears.
   task automatic build_models();
      int i;
      exp1_q.delete();
      exp0_q.delete();
      foreach (pix_q[k]) exp0_q.push_back({1'b0, pix_q[k]});
      i = 0;
      while (i < pix_q.size()) begin
         if ((i + 1 < pix_q.size()) && (pix_q[i+1] == 8'h00)) begin
            exp1_q.push_back({1'b1, pix_q[i]});
            i += 2;
         end else begin
            exp1_q.push_back({1'b0, pix_q[i]});
            i += 1;
         end
      end
   endtask

   task automatic gen_pixels(input int n, input int zero_pct);
      pix_q.delete();
      for (int k = 0; k < n; k++) begin
         if ($urandom_range(99) < zero_pct) pix_q.push_back(8'h00);
         else pix_q.push_back(8'($urandom_range(255, 1)));
      end
   endtask

   // Streams the first nbytes of pix_q; waits for frame_done only when the whole frame is sent.
   task automatic send_frame(input logic [AW-1:0] sa, input logic [AW-1:0] w, input logic [AW-1:0] h,
                             input int nbytes, input int gap_pct, input bit spurious,
                             output bit timed_out);
      int base;
      base = fdc1;
      timed_out = 1'b0;
      @(posedge clk); #1;
      start_addr = sa;
      img_width_size = w;
      img_height_size = h;
      pack_start = 1'b1;
      @(posedge clk); #1;
      pack_start = 1'b0;
      start_addr = ~sa;
      img_width_size = AW'($urandom);
      img_height_size = AW'($urandom);
      for (int k = 0; k < nbytes; k++) begin
         for (int b = 0; b < 8; b++) begin
            while ($urandom_range(99) < gap_pct) begin
               serial_en = 1'b0;
               serial_input = 1'($urandom);
               @(posedge clk); #1;
            end
            serial_en = 1'b1;
            serial_input = pix_q[k][b];
            if (spurious && k == 1 && b == 0) begin
               pack_start = 1'b1;
               start_addr = 10'h3f0;
            end
            @(posedge clk); #1;
            pack_start = 1'b0;
         end
      end
      serial_en = 1'b0;
      if (nbytes == pix_q.size()) begin
         timed_out = 1'b1;
         for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (fdc1 != base) begin
               timed_out = 1'b0;
               break;
            end
         end
         repeat (4) @(negedge clk);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (idle1 !== 1'b1) begin failures++; $display("FAIL reset_idle: got %b want 1", idle1); end
      checks++; if (we1 !== 1'b0 || en1 !== 1'b0) begin failures++; $display("FAIL reset_we: got we=%b en=%b want 0", we1, en1); end
      checks++; if (addr1 !== '0) begin failures++; $display("FAIL reset_addr: got %h want 0", addr1); end
      checks++; if (data1 !== '0) begin failures++; $display("FAIL reset_data: got %h want 0", data1); end
      checks++; if (fd1 !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", fd1); end
      checks++; if (wc1 !== '0) begin failures++; $display("FAIL reset_count: got %0d want 0", wc1); end
   endtask

   task automatic test_no_zeros();
      bit to;
      int fb;
      logic [AW-1:0] ea;
      pix_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
      build_models();
      wq1.delete();
      fb = fdc1;
      send_frame(10'h010, 10'd2, 10'd2, 9, 0, 1'b0, to);
      checks++; if (to) begin failures++; $display("FAIL no_zeros_done: frame_done never seen"); end
      checks++; if (wq1.size() != 9) begin failures++; $display("FAIL no_zeros_writes: got %0d want 9", wq1.size()); end
      for (int i = 0; i < wq1.size() && i < exp1_q.size(); i++) begin
         ea = 10'h010 + AW'(i);
         checks++;
         if (wq1[i] !== {ea, exp1_q[i]}) begin
            failures++; $display("FAIL no_zeros_word[%0d]: got %h want %h", i, wq1[i], {ea, exp1_q[i]});
         end
      end
      checks++; if (wc1 !== 11'd9) begin failures++; $display("FAIL no_zeros_count: got %0d want 9", wc1); end
      checks++; if (fdc1 - fb != 1) begin failures++; $display("FAIL no_zeros_pulse: got %0d cycles want 1", fdc1 - fb); end
      checks++; if (idle_at_done !== 1'b0) begin failures++; $display("FAIL no_zeros_idle_in_done: got %b want 0", idle_at_done); end
      checks++; if (idle1 !== 1'b1) begin failures++; $display("FAIL no_zeros_idle_after: got %b want 1", idle1); end
   endtask

   task automatic test_zero_skip();
      bit to;
      pix_q = '{8'h05, 8'h00, 8'h07, 8'h00, 8'h00, 8'h03};
      build_models();
      wq1.delete();
      wq0.delete();
      send_frame(10'h000, 10'd5, 10'd0, 6, 0, 1'b0, to);
      checks++; if (to) begin failures++; $display("FAIL skip_done: frame_done never seen"); end
      checks++; if (wq1.size() != 4) begin failures++; $display("FAIL skip_writes: got %0d want 4", wq1.size()); end
      for (int i = 0; i < wq1.size() && i < exp1_q.size(); i++) begin
         checks++;
         if (wq1[i] !== {AW'(i), exp1_q[i]}) begin
            failures++; $display("FAIL skip_word[%0d]: got %h want %h", i, wq1[i], {AW'(i), exp1_q[i]});
         end
      end
      checks++; if (wc1 !== 11'd4) begin failures++; $display("FAIL skip_count: got %0d want 4", wc1); end
      checks++; if (wq0.size() != 6) begin failures++; $display("FAIL plain_writes: got %0d want 6", wq0.size()); end
      for (int i = 0; i < wq0.size() && i < exp0_q.size(); i++) begin
         checks++;
         if (wq0[i] !== {AW'(i), exp0_q[i]}) begin
            failures++; $display("FAIL plain_word[%0d]: got %h want %h", i, wq0[i], {AW'(i), exp0_q[i]});
         end
      end
      checks++; if (wc0 !== 11'd6) begin failures++; $display("FAIL plain_count: got %0d want 6", wc0); end
   endtask

   task automatic test_last_zero();
      bit to;
      int fb;
      pix_q = '{8'h09, 8'h00};
      wq1.delete();
      fb = fdc1;
      send_frame(10'h3ff, 10'd1, 10'd0, 2, 0, 1'b0, to);
      checks++; if (to) begin failures++; $display("FAIL last_zero_done: frame_done never seen"); end
      checks++; if (wq1.size() != 1) begin failures++; $display("FAIL last_zero_writes: got %0d want 1", wq1.size()); end
      checks++;
      if (wq1.size() > 0 && wq1[0] !== {10'h3ff, 9'h109}) begin
         failures++; $display("FAIL last_zero_word: got %h want %h", wq1[0], {10'h3ff, 9'h109});
      end
      checks++; if (wc1 !== 11'd1) begin failures++; $display("FAIL last_zero_count: got %0d want 1", wc1); end
      checks++; if (fdc1 - fb != 1) begin failures++; $display("FAIL last_zero_pulse: got %0d want 1", fdc1 - fb); end
   endtask

   task automatic test_gaps();
      bit to;
      logic [AW+8:0] ref_q[$];
      logic [AW-1:0] ea;
      gen_pixels(100, 40);
      build_models();
      wq1.delete();
      send_frame(10'h080, 10'd9, 10'd9, 100, 0, 1'b0, to);
      ref_q = wq1;
      wq1.delete();
      wq0.delete();
      send_frame(10'h080, 10'd9, 10'd9, 100, 50, 1'b0, to);
      checks++; if (to) begin failures++; $display("FAIL gaps_done: frame_done never seen"); end
      checks++; if (wq1.size() != exp1_q.size()) begin failures++; $display("FAIL gaps_writes: got %0d want %0d", wq1.size(), exp1_q.size()); end
      checks++; if (wq1 != ref_q) begin failures++; $display("FAIL gaps_vs_gapfree: gapped image differs (%0d vs %0d words)", wq1.size(), ref_q.size()); end
      for (int i = 0; i < wq1.size() && i < exp1_q.size(); i++) begin
         ea = 10'h080 + AW'(i);
         checks++;
         if (wq1[i] !== {ea, exp1_q[i]}) begin
            failures++; $display("FAIL gaps_word[%0d]: got %h want %h", i, wq1[i], {ea, exp1_q[i]});
         end
      end
      checks++; if (wc1 !== (AW+1)'(exp1_q.size())) begin failures++; $display("FAIL gaps_count: got %0d want %0d", wc1, exp1_q.size()); end
      checks++; if (wq0.size() != 100) begin failures++; $display("FAIL gaps_plain_writes: got %0d want 100", wq0.size()); end
   endtask

   task automatic test_random_frames();
      bit to;
      logic [AW-1:0] sa, w, h, ea;
      int n, fb;
      for (int f = 0; f < 6; f++) begin
         sa = AW'($urandom);
         w = AW'($urandom_range(5));
         h = AW'($urandom_range(5));
         n = (int'(w) + 1) * (int'(h) + 1);
         gen_pixels(n, 50);
         build_models();
         wq1.delete();
         wq0.delete();
         fb = fdc1;
         send_frame(sa, w, h, n, 20, (f == 2) && (n > 1), to);
         checks++; if (to) begin failures++; $display("FAIL rand%0d_done: frame_done never seen", f); end
         checks++; if (fdc1 - fb != 1) begin failures++; $display("FAIL rand%0d_pulse: got %0d want 1", f, fdc1 - fb); end
         checks++; if (wq1.size() != exp1_q.size()) begin failures++; $display("FAIL rand%0d_writes: got %0d want %0d", f, wq1.size(), exp1_q.size()); end
         for (int i = 0; i < wq1.size() && i < exp1_q.size(); i++) begin
            ea = sa + AW'(i);
            checks++;
            if (wq1[i] !== {ea, exp1_q[i]}) begin
               failures++; $display("FAIL rand%0d_word[%0d]: got %h want %h", f, i, wq1[i], {ea, exp1_q[i]});
            end
         end
         checks++; if (wc1 !== (AW+1)'(exp1_q.size())) begin failures++; $display("FAIL rand%0d_count: got %0d want %0d", f, wc1, exp1_q.size()); end
         checks++; if (wq0.size() != exp0_q.size()) begin failures++; $display("FAIL rand%0d_plain_writes: got %0d want %0d", f, wq0.size(), exp0_q.size()); end
         for (int i = 0; i < wq0.size() && i < exp0_q.size(); i++) begin
            ea = sa + AW'(i);
            checks++;
            if (wq0[i] !== {ea, exp0_q[i]}) begin
               failures++; $display("FAIL rand%0d_plain_word[%0d]: got %h want %h", f, i, wq0[i], {ea, exp0_q[i]});
            end
         end
         checks++; if (wc0 !== (AW+1)'(n)) begin failures++; $display("FAIL rand%0d_plain_count: got %0d want %0d", f, wc0, n); end
      end
   endtask

   task automatic test_reset_mid_frame();
      bit to;
      logic [AW-1:0] ea;
      pix_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
      send_frame(10'h123, 10'd2, 10'd2, 3, 0, 1'b0, to);
      serial_en = 1'b1;
      for (int b = 0; b < 3; b++) begin
         serial_input = 1'b1;
         @(posedge clk); #1;
      end
      serial_en = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      checks++; if (idle1 !== 1'b1) begin failures++; $display("FAIL midrst_idle: got %b want 1", idle1); end
      checks++; if (we1 !== 1'b0 || fd1 !== 1'b0) begin failures++; $display("FAIL midrst_strobes: got we=%b done=%b want 0", we1, fd1); end
      checks++; if (addr1 !== '0 || data1 !== '0) begin failures++; $display("FAIL midrst_bus: got addr=%h data=%h want 0", addr1, data1); end
      checks++; if (wc1 !== '0) begin failures++; $display("FAIL midrst_count: got %0d want 0", wc1); end
      @(posedge clk); #1;
      reset_n = 1'b1;
      gen_pixels(9, 30);
      build_models();
      wq1.delete();
      send_frame(10'h200, 10'd2, 10'd2, 9, 0, 1'b0, to);
      checks++; if (to) begin failures++; $display("FAIL midrst_new_done: frame_done never seen"); end
      checks++; if (wq1.size() != exp1_q.size()) begin failures++; $display("FAIL midrst_new_writes: got %0d want %0d", wq1.size(), exp1_q.size()); end
      for (int i = 0; i < wq1.size() && i < exp1_q.size(); i++) begin
         ea = 10'h200 + AW'(i);
         checks++;
         if (wq1[i] !== {ea, exp1_q[i]}) begin
            failures++; $display("FAIL midrst_new_word[%0d]: got %h want %h", i, wq1[i], {ea, exp1_q[i]});
         end
      end
      checks++; if (wc1 !== (AW+1)'(exp1_q.size())) begin failures++; $display("FAIL midrst_new_count: got %0d want %0d", wc1, exp1_q.size()); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      test_reset();
      test_no_zeros();
      test_zero_skip();
      test_last_zero();
      test_gaps();
      test_random_frames();
      test_reset_mid_frame();
      checks++;
      if (en_bad != 0) begin
         failures++; $display("FAIL sram_en_vs_we: %0d cycles differ, want 0", en_bad);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
